instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetches one IWIDTH-bit instruction for the datapath from byte-wide instruction memory.
//  Sits directly upstream of the datapath: consumes its pc, drives its instr, and raises stall until instr is complete.
//  Performs IWIDTH/MWIDTH sequential byte reads over a req/ack memory port.
//  Supports redirect (flush) on taken branch/jump.
// PARAMETERS
//  DWIDTH  8   pc / memory address width (byte addressing)
//  IWIDTH  16  instruction width
//  MWIDTH  8   memory read-data width; BEATS = IWIDTH/MWIDTH, integer >= 1
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  pc           in   DWIDTH  address of next instruction (datapath pc)
//  fetch_en     in   1       request fetch of instruction at pc
//  flush        in   1       abandon current fetch/instruction (branch/jump taken)
//  mem_req      out  1       memory read request
//  mem_addr     out  DWIDTH  memory byte address
//  mem_ack      in   1       memory accepts req; mem_rdata valid this cycle
//  mem_rdata    in   MWIDTH  memory read data
//  instr        out  IWIDTH  assembled instruction to datapath
//  instr_valid  out  1       instr complete and stable
//  stall        out  1       datapath must hold pc and suppress writes
// BEHAVIOUR
//  Reset (async, immediate):
//   state=IDLE, beat=0, fetch_pc=0, mem_req=0, mem_addr=0, instr=0, instr_valid=0, stall=1.
//  States: IDLE, FETCH, VALID.
//   mem_req = (state==FETCH). instr_valid = (state==VALID). stall = ~instr_valid.
//  IDLE: if fetch_en, latch fetch_pc<=pc, beat<=0, go FETCH.
//  FETCH:
//   mem_addr = fetch_pc + beat, modulo 2^DWIDTH; pc=8'hFF wraps beat 1 to 8'h00.
//   mem_addr is stable while mem_req=1 and !mem_ack.
//   On edge with mem_ack=1: store mem_rdata into byte lane beat, big-endian (beat 0 -> instr[IWIDTH-1 -: MWIDTH]).
//    If beat==BEATS-1 go VALID; else beat<=beat+1, mem_req stays high.
//   Wait states (mem_ack=0) are unlimited; no timeout.
//  VALID:
//   instr holds until next fetch starts.
//   fetch_en -> latch pc, go FETCH; instr_valid falls the next cycle. instr keeps its old value until overwritten byte-by-byte.
//  Latency: fetch_en sampled at edge E0, zero-wait memory (ack every req cycle):
//   beat 0 acked at E1, beat 1 at E2, instr_valid=1 after E2.
//   Total BEATS edges after E0.
//  Flush (any state, priority over ack and fetch_en):
//   flush && !fetch_en -> IDLE, beat<=0; data of an ack in the same cycle is discarded.
//   flush && fetch_en  -> redirect: latch pc, beat<=0, FETCH.
//   mem_req drops for at most zero cycles on redirect; mem_addr changes to the new pc.
//  fetch_en in FETCH without flush is ignored; the current fetch completes.
//  Reset mid-fetch: outstanding memory transaction abandoned; mem_req=0 immediately.
// TESTING
//  1 Reset: assert reset mid-FETCH -> mem_req=0, instr_valid=0, stall=1, instr=0 same cycle.
//  2 Zero-wait fetch: pc=8'h10, mem[10]=8'hA5, mem[11]=8'h3C, fetch_en 1 cycle -> addrs 10,11; instr=16'hA53C, instr_valid 2 edges later.
//  3 Wait states: ack delayed 3 cycles on beat 0 -> mem_addr held 8'h10; instr=16'hA53C; stall=1 throughout.
//  4 Wrap: pc=8'hFF, mem[FF]=8'h12, mem[00]=8'h34 -> addrs FF,00; instr=16'h1234.
//  5 Redirect: flush+fetch_en (pc=8'h40) during beat 1 of fetch at 8'h10, ack same cycle -> byte ignored; next addrs 40,41; instr=mem[40]:mem[41].
//  6 Flush in VALID without fetch_en -> IDLE, instr_valid=0, stall=1, mem_req=0; back-to-back fetch_en in VALID -> new fetch, no idle gap.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: assembles one IWIDTH-bit instruction from BEATS big-endian
// byte reads over a req/ack memory port, stalling the datapath until it is complete.
module instr_fetch_unit #(
   parameter int DWIDTH = 8,
   parameter int IWIDTH = 16,
   parameter int MWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] pc,
   input  logic              fetch_en,
   input  logic              flush,
   output logic              mem_req,
   output logic [DWIDTH-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [MWIDTH-1:0] mem_rdata,
   output logic [IWIDTH-1:0] instr,
   output logic              instr_valid,
   output logic              stall
);

   localparam int BEATS = IWIDTH / MWIDTH;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

   state_t            state, stateNext;
   logic [BW-1:0]     beat, beatNext;
   logic [DWIDTH-1:0] fetchPc, fetchPcNext;
   logic              storeByte;
   logic              lastBeat;

   assign lastBeat = (beat == BW'(BEATS - 1));

   // Flush outranks everything; with fetch_en it redirects straight into a new fetch
   always_comb begin
      stateNext   = state;
      beatNext    = beat;
      fetchPcNext = fetchPc;
      storeByte   = 1'b0;
      if (flush) begin
         beatNext = '0;
         if (fetch_en) begin
            stateNext   = FETCH;
            fetchPcNext = pc;
         end else begin
            stateNext = IDLE;
         end
      end else begin
         case (state)
            IDLE, VALID: begin
               if (fetch_en) begin
                  stateNext   = FETCH;
                  fetchPcNext = pc;
                  beatNext    = '0;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  storeByte = 1'b1;
                  if (lastBeat) begin
                     stateNext = VALID;
                  end else begin
                     beatNext = beat + BW'(1);
                  end
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Beat 0 lands in the most significant lane; untouched lanes keep the old instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat    <= '0;
         fetchPc <= '0;
         instr   <= '0;
      end else begin
         beat    <= beatNext;
         fetchPc <= fetchPcNext;
         if (storeByte) begin
            instr[IWIDTH - 1 - int'(beat) * MWIDTH -: MWIDTH] <= mem_rdata;
         end
      end
   end

   assign mem_req     = (state == FETCH);
   assign mem_addr    = (state == FETCH) ? (fetchPc + DWIDTH'(beat)) : '0;
   assign instr_valid = (state == VALID);
   assign stall       = ~instr_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: table of fetches plus hand-written
// sequences for redirect, flush and reset in the middle of a fetch.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic [7:0]  pc;
   logic        fetch_en;
   logic        flush;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        stall;

   logic [7:0]  mem [256];
   logic [15:0] lastInstr;
   int          checks;
   int          errors;

   typedef struct {
      logic [7:0]  pc;
      int          waits;
      logic [7:0]  addr0;
      logic [7:0]  addr1;
      logic [15:0] instr;
      string       name;
   } vec_t;

   vec_t vecs [4];

   instr_fetch_unit #(.DWIDTH(8), .IWIDTH(16), .MWIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .fetch_en    (fetch_en),
      .flush       (flush),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete fetch with a given number of wait cycles on beat 0; fetch_en is
   // held high during the waits to show it is ignored while a fetch is in flight
   task automatic applyStimulus(input vec_t v);
      pc       = v.pc;
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      checkOutput({v.name, " req0"}, 32'(mem_req), 32'd1);
      checkOutput({v.name, " addr0"}, 32'(mem_addr), 32'(v.addr0));
      checkOutput({v.name, " valid0"}, 32'(instr_valid), 32'd0);
      checkOutput({v.name, " oldInstr"}, 32'(instr), 32'(lastInstr));
      for (int w = 0; w < v.waits; w++) begin
         mem_ack  = 1'b0;
         fetch_en = 1'b1;
         pc       = ~v.pc;
         tick();
         checkOutput({v.name, " waitAddr"}, 32'(mem_addr), 32'(v.addr0));
         checkOutput({v.name, " waitStall"}, 32'(stall), 32'd1);
      end
      fetch_en  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      tick();
      checkOutput({v.name, " addr1"}, 32'(mem_addr), 32'(v.addr1));
      checkOutput({v.name, " req1"}, 32'(mem_req), 32'd1);
      mem_rdata = mem[mem_addr];
      tick();
      mem_ack = 1'b0;
      checkOutput({v.name, " instr"}, 32'(instr), 32'(v.instr));
      checkOutput({v.name, " valid"}, 32'(instr_valid), 32'd1);
      checkOutput({v.name, " stall"}, 32'(stall), 32'd0);
      checkOutput({v.name, " reqDone"}, 32'(mem_req), 32'd0);
      lastInstr = v.instr;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      lastInstr = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hA5;
      mem[8'h11] = 8'h3C;
      mem[8'hFF] = 8'h12;
      mem[8'h00] = 8'h34;
      mem[8'h40] = 8'hC7;
      mem[8'h41] = 8'hE2;

      vecs[0] = '{pc: 8'h10, waits: 0, addr0: 8'h10, addr1: 8'h11, instr: 16'hA53C, name: "zeroWait"};
      vecs[1] = '{pc: 8'h10, waits: 3, addr0: 8'h10, addr1: 8'h11, instr: 16'hA53C, name: "waitStates"};
      vecs[2] = '{pc: 8'h40, waits: 1, addr0: 8'h40, addr1: 8'h41, instr: 16'hC7E2, name: "other"};
      vecs[3] = '{pc: 8'hFF, waits: 0, addr0: 8'hFF, addr1: 8'h00, instr: 16'h1234, name: "wrap"};

      reset     = 1'b1;
      pc        = 8'h00;
      fetch_en  = 1'b0;
      flush     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      #1;
      checkOutput("rstReq", 32'(mem_req), 32'd0);
      checkOutput("rstAddr", 32'(mem_addr), 32'd0);
      checkOutput("rstInstr", 32'(instr), 32'd0);
      checkOutput("rstValid", 32'(instr_valid), 32'd0);
      checkOutput("rstStall", 32'(stall), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("idleReq", 32'(mem_req), 32'd0);

      // Back-to-back fetches: each one starts straight from VALID
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

      // Redirect during beat 1 of a fetch at 10; the acked byte must be dropped
      pc       = 8'h10;
      fetch_en = 1'b1;
      tick();
      fetch_en  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      tick();
      checkOutput("redirBeat1Addr", 32'(mem_addr), 32'h11);
      flush     = 1'b1;
      fetch_en  = 1'b1;
      pc        = 8'h40;
      mem_rdata = mem[mem_addr];
      tick();
      flush    = 1'b0;
      fetch_en = 1'b0;
      checkOutput("redirReq", 32'(mem_req), 32'd1);
      checkOutput("redirAddr", 32'(mem_addr), 32'h40);
      checkOutput("redirDiscard", 32'(instr), 32'hA534);
      checkOutput("redirValid", 32'(instr_valid), 32'd0);
      mem_rdata = mem[mem_addr];
      tick();
      checkOutput("redirAddr1", 32'(mem_addr), 32'h41);
      mem_rdata = mem[mem_addr];
      tick();
      mem_ack = 1'b0;
      checkOutput("redirInstr", 32'(instr), 32'hC7E2);
      checkOutput("redirDone", 32'(instr_valid), 32'd1);
      lastInstr = 16'hC7E2;

      // Flush in VALID without fetch_en returns to IDLE and stays there
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flushValid", 32'(instr_valid), 32'd0);
      checkOutput("flushStall", 32'(stall), 32'd1);
      checkOutput("flushReq", 32'(mem_req), 32'd0);
      tick();
      checkOutput("flushIdle", 32'(mem_req), 32'd0);
      applyStimulus(vecs[0]);

      // Reset asserted mid-fetch takes effect without waiting for a clock edge
      pc       = 8'h40;
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      tick();
      checkOutput("preRstReq", 32'(mem_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midRstReq", 32'(mem_req), 32'd0);
      checkOutput("midRstValid", 32'(instr_valid), 32'd0);
      checkOutput("midRstStall", 32'(stall), 32'd1);
      checkOutput("midRstInstr", 32'(instr), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("postRstReq", 32'(mem_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
